// File: rtl/bsg_link_channel_scheduler.sv
// Stripes one valid/ready link stream across parallel output channels, picking
// eligible (enabled, credited) channels round-robin and tracking returned credits.
module bsg_link_channel_scheduler #(
    parameter int width_p                = 9,
    parameter int channels_p             = 2,
    parameter int credit_els_p           = 16,
    parameter int lg_credit_decimation_p = 2
) (
    input  logic                                              clk_i,
    input  logic                                              reset_i,
    input  logic [channels_p-1:0]                             en_i,
    input  logic                                              v_i,
    input  logic [width_p-1:0]                                data_i,
    output logic                                              ready_o,
    output logic [channels_p-1:0]                             ch_v_o,
    output logic [channels_p*width_p-1:0]                     ch_data_o,
    input  logic [channels_p-1:0]                             ch_tkn_i,
    output logic [channels_p*$clog2(credit_els_p+1)-1:0]      credit_o,
    output logic                                              overflow_o
);

    localparam int CW       = $clog2(credit_els_p + 1);
    localparam int PW       = $clog2(channels_p);
    localparam int TKN_INT  = 1 << lg_credit_decimation_p;
    localparam int LAST_INT = channels_p - 1;

    localparam logic [CW:0]   CREDIT_MAX  = credit_els_p[CW:0];
    localparam logic [CW:0]   TKN_CREDITS = TKN_INT[CW:0];
    localparam logic [CW:0]   ONE_CREDIT  = {{CW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] LAST_CH     = LAST_INT[PW-1:0];

    logic [channels_p-1:0][CW-1:0]      r_credit;
    logic [channels_p-1:0][CW-1:0]      w_credit_nxt;
    logic [channels_p-1:0][width_p-1:0] r_data;
    logic [channels_p-1:0]              r_v;
    logic [channels_p-1:0]              w_elig;
    logic [PW-1:0]                      r_ptr;
    logic [PW-1:0]                      w_sel;
    logic [PW-1:0]                      w_cand;
    logic [PW-1:0]                      w_ptr_nxt;
    logic [CW:0]                        w_sum;
    logic                               w_found;
    logic                               w_accept;
    logic                               w_ovf;
    logic                               r_ovf;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < channels_p; i++) begin
            w_elig[i] = en_i[i] && (r_credit[i] != '0);
        end
    end

    // First eligible channel at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < channels_p; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % channels_p);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign ready_o   = w_found & ~reset_i;
    assign w_accept  = v_i & ready_o;
    assign w_ptr_nxt = (w_sel == LAST_CH) ? '0 : w_sel + PW'(1);

    // One bit of headroom so a token on a full counter is seen as overflow.
    always_comb begin
        w_credit_nxt = '0;
        w_sum        = '0;
        w_ovf        = 1'b0;
        for (int i = 0; i < channels_p; i++) begin
            w_sum = {1'b0, r_credit[i]};
            if (w_accept && (w_sel == PW'(i))) begin
                w_sum = w_sum - ONE_CREDIT;
            end
            if (ch_tkn_i[i]) begin
                w_sum = w_sum + TKN_CREDITS;
            end
            if (w_sum > CREDIT_MAX) begin
                w_credit_nxt[i] = CREDIT_MAX[CW-1:0];
                w_ovf           = 1'b1;
            end else begin
                w_credit_nxt[i] = w_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < channels_p; i++) begin
                r_credit[i] <= CREDIT_MAX[CW-1:0];
            end
            r_ptr  <= '0;
            r_v    <= '0;
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            r_v      <= '0;
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_accept) begin
                r_v[w_sel]    <= 1'b1;
                r_data[w_sel] <= data_i;
                r_ptr         <= w_ptr_nxt;
            end
        end
    end

    assign ch_v_o     = r_v;
    assign ch_data_o  = r_data;
    assign credit_o   = r_credit;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_bsg_link_channel_scheduler.sv
// Randomized and directed bench for bsg_link_channel_scheduler against a
// cycle-level reference model of credits, round-robin choice and dispatch.
module tb_bsg_link_channel_scheduler;

    localparam int W  = 9;
    localparam int N  = 2;
    localparam int CW = 5;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [N-1:0]     en_i;
    logic             v_i;
    logic [W-1:0]     data_i;
    logic             ready_o;
    logic [N-1:0]     ch_v_o;
    logic [N*W-1:0]   ch_data_o;
    logic [N-1:0]     ch_tkn_i;
    logic [N*CW-1:0]  credit_o;
    logic             overflow_o;

    always #5 clk_i = ~clk_i;

    bsg_link_channel_scheduler #(
        .width_p(W), .channels_p(N), .credit_els_p(16), .lg_credit_decimation_p(2)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .ch_v_o(ch_v_o), .ch_data_o(ch_data_o),
        .ch_tkn_i(ch_tkn_i), .credit_o(credit_o), .overflow_o(overflow_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int           m_credit[N];
    int           m_ptr;
    int           m_accepts;
    logic         m_ovf;
    logic [N-1:0] m_v;
    logic [N*W-1:0] m_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check ready_o, clock it, then check registered outputs.
    task automatic step(input logic rst, input logic [N-1:0] en, input logic v,
                        input logic [W-1:0] d, input logic [N-1:0] tkn);
        int   sel;
        bit   acc;
        int   nxt;
        logic [N*CW-1:0] ec;
        reset_i  = rst;
        en_i     = en;
        v_i      = v;
        data_i   = d;
        ch_tkn_i = tkn;
        #1;
        sel = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (sel < 0 && en[c] && m_credit[c] > 0) sel = c;
        end
        check_val("ready", ready_o, (!rst && sel >= 0));
        acc = v && !rst && (sel >= 0);
        @(posedge clk_i);
        #1;
        if (rst) begin
            for (int i = 0; i < N; i++) m_credit[i] = 16;
            m_ptr  = 0;
            m_v    = '0;
            m_data = '0;
            m_ovf  = 1'b0;
        end else begin
            m_v = '0;
            for (int i = 0; i < N; i++) begin
                nxt = m_credit[i] - ((acc && sel == i) ? 1 : 0) + (tkn[i] ? 4 : 0);
                if (nxt > 16) begin
                    nxt   = 16;
                    m_ovf = 1'b1;
                end
                m_credit[i] = nxt;
            end
            if (acc) begin
                m_v[sel]            = 1'b1;
                m_data[sel*W +: W]  = d;
                m_ptr               = (sel + 1) % N;
                m_accepts++;
            end
        end
        for (int i = 0; i < N; i++) ec[i*CW +: CW] = 5'(m_credit[i]);
        check_val("ch_v", ch_v_o, m_v);
        check_val("ch_data", ch_data_o, m_data);
        check_val("credit", credit_o, ec);
        check_val("overflow", overflow_o, m_ovf);
    endtask

    initial begin
        int base;
        int hits;
        m_accepts = 0;
        m_ptr     = 0;
        m_ovf     = 1'b0;
        m_v       = '0;
        m_data    = '0;
        for (int i = 0; i < N; i++) m_credit[i] = 16;

        // Reset and idle
        step(1'b1, 2'b11, 1'b0, 9'h0, 2'b00);
        step(1'b1, 2'b11, 1'b0, 9'h0, 2'b00);
        step(1'b0, 2'b11, 1'b0, 9'h0, 2'b00);
        check_val("t1_credit", credit_o, 10'h210);
        check_val("t1_ready", ready_o, 1'b1);

        // Alternating dispatch
        for (int d = 1; d <= 4; d++) step(1'b0, 2'b11, 1'b1, 9'(d), 2'b00);
        check_val("t2_data", ch_data_o, {9'h004, 9'h003});
        step(1'b0, 2'b11, 1'b0, 9'h0, 2'b00);
        check_val("t2_idle_v", ch_v_o, 2'b00);

        // Drain all credits, then one token on ch1
        step(1'b1, 2'b11, 1'b0, 9'h0, 2'b00);
        base = m_accepts;
        for (int i = 0; i < 36; i++) step(1'b0, 2'b11, 1'b1, 9'($urandom), 2'b00);
        check_val("t3_accepts", m_accepts - base, 32);
        check_val("t3_ready_empty", ready_o, 1'b0);
        check_val("t3_credit_empty", credit_o, 10'h000);
        step(1'b0, 2'b11, 1'b0, 9'h0, 2'b10);
        check_val("t3_credit1", credit_o, 10'h080);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'b11, 1'b1, 9'(9'h40 + i), 2'b00);
            if (ch_v_o[1]) hits++;
        end
        check_val("t3_ch1_words", hits, 4);

        // Net decrement plus token
        step(1'b1, 2'b11, 1'b0, 9'h0, 2'b00);
        for (int i = 0; i < 15; i++) step(1'b0, 2'b01, 1'b1, 9'(i), 2'b00);
        check_val("t4_credit0_one", credit_o[4:0], 5'd1);
        step(1'b0, 2'b01, 1'b1, 9'h1aa, 2'b01);
        check_val("t4_credit0_net", credit_o[4:0], 5'd4);
        check_val("t4_no_ovf", overflow_o, 1'b0);

        // Overflow is sticky until reset
        step(1'b1, 2'b11, 1'b0, 9'h0, 2'b00);
        step(1'b0, 2'b11, 1'b0, 9'h0, 2'b01);
        check_val("t5_ovf", overflow_o, 1'b1);
        check_val("t5_sat", credit_o[4:0], 5'd16);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 1'b0, 9'h0, 2'b00);
        check_val("t5_ovf_sticky", overflow_o, 1'b1);
        step(1'b1, 2'b11, 1'b0, 9'h0, 2'b00);
        check_val("t5_ovf_clear", overflow_o, 1'b0);

        // Single enabled channel with pointer on ch1, then reset mid-burst
        step(1'b0, 2'b11, 1'b1, 9'h011, 2'b00);
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b01, 1'b1, 9'(9'h20 + i), 2'b00);
            if (ch_v_o[0]) hits++;
        end
        check_val("t6_ch0_only", hits, 3);
        step(1'b0, 2'b11, 1'b1, 9'h0aa, 2'b00);
        step(1'b0, 2'b11, 1'b1, 9'h0bb, 2'b00);
        step(1'b1, 2'b11, 1'b1, 9'h0cc, 2'b00);
        check_val("t6_rst_v", ch_v_o, 2'b00);
        check_val("t6_rst_credit", credit_o, 10'h210);
        step(1'b0, 2'b11, 1'b1, 9'h0dd, 2'b00);
        check_val("t6_ptr_zero", ch_v_o, 2'b01);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic [N-1:0] tkn;
            for (int c = 0; c < N; c++) tkn[c] = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0), 9'($urandom), tkn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
